// File: rtl/battle_engine_if.sv
// Bus between collision/keyboard logic, the battle engine and the HUD renderer.
// The master side drives encounter requests and keys; the slave side returns HP and status.
interface battle_engine_if #(
  parameter int HP_W  = 8,
  parameter int DMG_W = 7
);
  logic             col_e;
  logic             boss;
  logic [DMG_W-1:0] player_hit;
  logic [DMG_W-1:0] enemy_hit;
  logic [7:0]       key_in;
  logic [HP_W-1:0]  HP_player;
  logic [HP_W-1:0]  HP_enemy;
  logic [2:0]       p_attack;
  logic [2:0]       e_attack;
  logic             in_battle;
  logic             battle_won;
  logic             battle_lost;

  modport master (
    output col_e, boss, player_hit, enemy_hit, key_in,
    input  HP_player, HP_enemy, p_attack, e_attack, in_battle, battle_won, battle_lost
  );

  modport slave (
    input  col_e, boss, player_hit, enemy_hit, key_in,
    output HP_player, HP_enemy, p_attack, e_attack, in_battle, battle_won, battle_lost
  );
endinterface

// File: rtl/battle_engine.sv
// Turn-based encounter engine: spawns enemy HP on collision, alternates player and
// enemy turns with saturating damage, and reports win/loss to the HUD.
module battle_engine #(
  parameter int          HP_W        = 8,
  parameter int          DMG_W       = 7,
  parameter int          PLAYER_HP   = 100,
  parameter int          BOSS_HP     = 150,
  parameter int          ENEMY_MIN   = 51,
  parameter int          ENEMY_SPAN  = 50,
  parameter int          RND_W       = 6,
  parameter int          ENEMY_DELAY = 8,
  parameter logic [7:0]  KEY_LIGHT   = 8'h1C,
  parameter logic [7:0]  KEY_HEAVY   = 8'h1B,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic            clk_b,
  input logic            rst_n,
  battle_engine_if.slave bus
);
  localparam int AW = HP_W + 2;
  localparam int CW = (ENEMY_DELAY > 1) ? $clog2(ENEMY_DELAY) : 1;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PLAYER_TURN = 3'd1,
    ENEMY_WAIT  = 3'd2,
    WIN         = 3'd3,
    LOSE        = 3'd4
  } state_t;

  state_t          state_r;
  logic [15:0]     lfsr_r;
  logic [7:0]      key_prev_r;
  logic [CW-1:0]   wait_cnt_r;
  logic            boss_r;
  logic [HP_W-1:0] hp_player_r;
  logic [HP_W-1:0] hp_enemy_r;
  logic [2:0]      p_attack_r;
  logic [2:0]      e_attack_r;
  logic            in_battle_r;
  logic            won_r;
  logic            lost_r;

  logic            key_ok_s;
  logic            heavy_s;
  logic            miss_s;
  logic [RND_W-1:0] rnd_s;
  logic [RND_W-1:0] r_s;
  logic [HP_W-1:0] spawn_hp_s;
  logic [AW-1:0]   p_dmg_s;
  logic [AW-1:0]   e_dmg_s;
  logic [HP_W-1:0] enemy_after_s;
  logic [HP_W-1:0] player_after_s;
  logic [2:0]      p_code_s;
  logic            lfsr_fb_s;

  // Turn arithmetic: spawn HP, damage amounts and saturated HP results.
  always_comb begin
    lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
    key_ok_s  = ((bus.key_in == KEY_LIGHT) || (bus.key_in == KEY_HEAVY)) && (key_prev_r == 8'h00);
    heavy_s   = (bus.key_in == KEY_HEAVY);
    miss_s    = (lfsr_r[1:0] == 2'b00);
    rnd_s     = lfsr_r[RND_W-1:0];
    // Fold out-of-span draws back into 0..ENEMY_SPAN instead of rejecting them.
    if (AW'(rnd_s) > AW'(ENEMY_SPAN)) begin
      r_s = RND_W'(AW'(rnd_s) - AW'(ENEMY_SPAN) - AW'(1));
    end else begin
      r_s = rnd_s;
    end
    if (bus.boss) begin
      spawn_hp_s = HP_W'(BOSS_HP);
    end else begin
      spawn_hp_s = HP_W'(ENEMY_MIN) + HP_W'(r_s);
    end
    if (!heavy_s) begin
      p_dmg_s  = AW'(bus.player_hit);
      p_code_s = 3'd1;
    end else if (miss_s) begin
      p_dmg_s  = {AW{1'b0}};
      p_code_s = 3'd4;
    end else begin
      p_dmg_s  = AW'({bus.player_hit, 1'b0});
      p_code_s = 3'd2;
    end
    if (boss_r) begin
      e_dmg_s = AW'(bus.enemy_hit) + AW'(bus.enemy_hit >> 1);
    end else begin
      e_dmg_s = AW'(bus.enemy_hit);
    end
    // Compare before subtracting so HP never wraps below zero.
    if (p_dmg_s >= AW'(hp_enemy_r)) begin
      enemy_after_s = {HP_W{1'b0}};
    end else begin
      enemy_after_s = hp_enemy_r - p_dmg_s[HP_W-1:0];
    end
    if (e_dmg_s >= AW'(hp_player_r)) begin
      player_after_s = {HP_W{1'b0}};
    end else begin
      player_after_s = hp_player_r - e_dmg_s[HP_W-1:0];
    end
  end

  // Encounter FSM with registered HP, attack codes and status flags.
  always_ff @(posedge clk_b) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lfsr_r      <= LFSR_SEED;
      key_prev_r  <= 8'h00;
      wait_cnt_r  <= {CW{1'b0}};
      boss_r      <= 1'b0;
      hp_player_r <= HP_W'(PLAYER_HP);
      hp_enemy_r  <= {HP_W{1'b0}};
      p_attack_r  <= 3'd0;
      e_attack_r  <= 3'd0;
      in_battle_r <= 1'b0;
      won_r       <= 1'b0;
      lost_r      <= 1'b0;
    end else begin
      lfsr_r     <= {lfsr_r[14:0], lfsr_fb_s};
      key_prev_r <= bus.key_in;
      case (state_r)
        IDLE: begin
          if (bus.col_e) begin
            state_r     <= PLAYER_TURN;
            hp_enemy_r  <= spawn_hp_s;
            boss_r      <= bus.boss;
            p_attack_r  <= 3'd0;
            e_attack_r  <= 3'd0;
            in_battle_r <= 1'b1;
          end
        end
        PLAYER_TURN: begin
          if (key_ok_s) begin
            hp_enemy_r <= enemy_after_s;
            p_attack_r <= p_code_s;
            wait_cnt_r <= {CW{1'b0}};
            if (enemy_after_s == {HP_W{1'b0}}) begin
              state_r     <= WIN;
              in_battle_r <= 1'b0;
              won_r       <= 1'b1;
            end else begin
              state_r <= ENEMY_WAIT;
            end
          end
        end
        ENEMY_WAIT: begin
          if (wait_cnt_r == CW'(ENEMY_DELAY - 1)) begin
            hp_player_r <= player_after_s;
            e_attack_r  <= boss_r ? 3'd2 : 3'd1;
            if (player_after_s == {HP_W{1'b0}}) begin
              state_r     <= LOSE;
              in_battle_r <= 1'b0;
              lost_r      <= 1'b1;
            end else begin
              state_r <= PLAYER_TURN;
            end
          end else begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
          end
        end
        WIN: begin
          hp_enemy_r <= {HP_W{1'b0}};
          if (!bus.col_e) begin
            state_r <= IDLE;
            won_r   <= 1'b0;
          end
        end
        LOSE: begin
          state_r <= LOSE;
        end
        default: begin
          state_r     <= IDLE;
          in_battle_r <= 1'b0;
          won_r       <= 1'b0;
          lost_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HP_player   = hp_player_r;
  assign bus.HP_enemy    = hp_enemy_r;
  assign bus.p_attack    = p_attack_r;
  assign bus.e_attack    = e_attack_r;
  assign bus.in_battle   = in_battle_r;
  assign bus.battle_won  = won_r;
  assign bus.battle_lost = lost_r;
endmodule

// File: tb/tb_battle_engine.sv
// Scoreboard bench for battle_engine: stimulus queues cycle-tagged expectations,
// a monitor on the falling edge pops and compares them against the outputs.
module tb_battle_engine;
  logic clk_b = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_b = ~clk_b;

  battle_engine_if #(.HP_W(8), .DMG_W(7)) bus ();
  battle_engine dut (.clk_b(clk_b), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    int    at;
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  logic [15:0] mlfsr = 16'h0000;

  // Cycle count and reference LFSR, both advanced on the active edge.
  initial begin
    forever begin
      @(posedge clk_b);
      cyc = cyc + 1;
      if (!rst_n) mlfsr = 16'hACE1;
      else        mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
    end
  end

  function automatic int actual(input int sel);
    case (sel)
      0: actual = int'(bus.HP_player);
      1: actual = int'(bus.HP_enemy);
      2: actual = int'(bus.p_attack);
      3: actual = int'(bus.e_attack);
      4: actual = int'(bus.in_battle);
      5: actual = int'(bus.battle_won);
      6: actual = int'(bus.battle_lost);
      7: actual = ((bus.HP_enemy >= 8'd51) && (bus.HP_enemy <= 8'd101)) ? 1 : 0;
      default: actual = -1;
    endcase
  endfunction

  // Monitor: compare every expectation whose target cycle has arrived.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(negedge clk_b);
      while (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        a = actual(e.sel);
        n_total = n_total + 1;
        if (e.at != cyc) begin
          $display("FAIL %s: stale check (due cycle %0d, now %0d) actual=%0d required=%0d", e.name, e.at, cyc, a, e.val);
        end else if (a != e.val) begin
          $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", e.name, a, e.val, cyc);
        end else begin
          n_pass = n_pass + 1;
        end
      end
    end
  end

  task automatic expect_v(input string name, input int sel, input int val);
    exp_t e;
    e.at = cyc; e.name = name; e.sel = sel; e.val = val;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int spawn_hp(input logic [15:0] l);
    logic [5:0] rnd;
    rnd = l[5:0];
    spawn_hp = (rnd > 6'd50) ? 51 + int'(rnd) - 51 : 51 + int'(rnd);
  endfunction

  task automatic press(input logic [7:0] k);
    bus.key_in = k;
    tick();
    bus.key_in = 8'h00;
  endtask

  initial begin
    int he;
    int exp_hp;
    bus.col_e = 1'b0; bus.boss = 1'b0; bus.player_hit = 7'd0; bus.enemy_hit = 7'd0; bus.key_in = 8'h00;

    // Reset state
    rst_n = 1'b0;
    tick();
    expect_v("rst_hp_player", 0, 100); expect_v("rst_hp_enemy", 1, 0);
    expect_v("rst_p_attack", 2, 0);    expect_v("rst_e_attack", 3, 0);
    expect_v("rst_in_battle", 4, 0);   expect_v("rst_won", 5, 0); expect_v("rst_lost", 6, 0);
    rst_n = 1'b1;
    tick();

    // Boss encounter, light hit, boss strike
    bus.boss = 1'b1; bus.col_e = 1'b1;
    tick();
    expect_v("boss_hp", 1, 150); expect_v("boss_in_battle", 4, 1);
    bus.boss = 1'b0; bus.col_e = 1'b0;
    bus.player_hit = 7'd20; bus.enemy_hit = 7'd10; bus.key_in = 8'h1C;
    tick();
    expect_v("light_hp_enemy", 1, 130); expect_v("light_p_attack", 2, 1);
    ticks(7);
    expect_v("wait7_hp_player", 0, 100); expect_v("wait7_e_attack", 3, 0);
    tick();
    expect_v("boss_strike_hp", 0, 85); expect_v("boss_strike_e", 3, 2);
    ticks(12);
    expect_v("held_key_once", 1, 130);
    bus.key_in = 8'h00;
    tick();
    press(8'h1C);
    expect_v("second_press", 1, 110);

    // Heavy miss then heavy hit, enemy strikes with zero damage
    bus.enemy_hit = 7'd0;
    ticks(8);
    expect_v("zero_strike_hp", 0, 85);
    for (int i = 0; i < 64 && mlfsr[1:0] != 2'b00; i++) tick();
    he = (mlfsr[1:0] == 2'b00) ? 110 : 70;
    press(8'h1B);
    expect_v("heavy_miss_hp", 1, he); expect_v("heavy_miss_code", 2, (he == 110) ? 4 : 2);
    ticks(8);
    for (int i = 0; i < 64 && mlfsr[1:0] == 2'b00; i++) tick();
    he = (he > 40) ? he - 40 : 0;
    press(8'h1B);
    expect_v("heavy_hit_hp", 1, he); expect_v("heavy_hit_code", 2, 2);
    ticks(8);

    // Drop enemy to 5, then saturating hit wins
    bus.player_hit = 7'(he - 5);
    press(8'h1C);
    expect_v("to_five", 1, 5);
    ticks(8);
    bus.player_hit = 7'd20;
    press(8'h1C);
    expect_v("sat_hp_enemy", 1, 0); expect_v("win_flag", 5, 1); expect_v("win_not_in_battle", 4, 0);
    bus.col_e = 1'b1;
    ticks(2);
    expect_v("win_held_by_col", 5, 1);
    bus.col_e = 1'b0;
    tick();
    expect_v("win_to_idle", 5, 0); expect_v("hp_carry", 0, 85);

    // Normal-enemy spawn sweep
    for (int n = 0; n < 1000; n++) begin
      exp_hp = spawn_hp(mlfsr);
      bus.col_e = 1'b1;
      tick();
      expect_v("spawn_exact", 1, exp_hp); expect_v("spawn_range", 7, 1);
      bus.col_e = 1'b0; bus.player_hit = 7'd127;
      press(8'h1C);
      tick();
    end
    expect_v("sweep_won_cleared", 5, 0);

    // Loss path
    exp_hp = spawn_hp(mlfsr);
    bus.col_e = 1'b1;
    tick();
    bus.col_e = 1'b0; bus.player_hit = 7'd1;
    press(8'h1C);
    expect_v("loss_hit1", 1, exp_hp - 1);
    bus.enemy_hit = 7'd75;
    ticks(8);
    expect_v("loss_hp10", 0, 10); expect_v("normal_e_attack", 3, 1);
    press(8'h1C);
    bus.enemy_hit = 7'd30;
    ticks(8);
    expect_v("loss_hp0", 0, 0); expect_v("lost_flag", 6, 1); expect_v("lost_not_in_battle", 4, 0);
    for (int i = 0; i < 10; i++) begin
      bus.col_e = i[0];
      bus.key_in = i[0] ? 8'h1C : 8'h00;
      tick();
    end
    bus.col_e = 1'b0; bus.key_in = 8'h00;
    expect_v("lost_sticky", 6, 1); expect_v("lost_hp_sticky", 0, 0);

    // Reset aborts an enemy wait
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_v("rst_clear_lost", 6, 0); expect_v("rst_hp_back", 0, 100);
    bus.col_e = 1'b1;
    tick();
    bus.col_e = 1'b0;
    press(8'h1C);
    ticks(3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_v("midrst_hp", 0, 100); expect_v("midrst_idle", 4, 0); expect_v("midrst_enemy", 1, 0);
    ticks(10);
    expect_v("midrst_no_strike", 0, 100); expect_v("midrst_no_e", 3, 0);

    ticks(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total = n_total + 1;
      $display("FAIL %s: never compared actual=none required=%0d", e.name, e.val);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
